// File: rtl/i2c_burst_master.sv
// Wishbone master that sequences the I2C core register map to perform
// multi-byte register-addressed writes and reads. It handles slave NACK and
// status-poll timeouts, and always ends a failed transfer with a STOP.
`timescale 1ns/1ps
module i2c_burst_master #(
    parameter logic [15:0] PRESCALE    = 16'h00C8,
    parameter int          MAX_BYTES   = 4,
    parameter int          ADDR_BYTES  = 1,
    parameter int          TIMEOUT_CYC = 1024,
    parameter int          LEN_W       = $clog2(MAX_BYTES + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    rw,
    input  logic [6:0]              slave_addr,
    input  logic [8*ADDR_BYTES-1:0] mem_addr,
    input  logic [LEN_W-1:0]        len,
    input  logic [8*MAX_BYTES-1:0]  wr_data,
    output logic [8*MAX_BYTES-1:0]  rd_data,
    output logic                    busy,
    output logic                    done,
    output logic                    err_nack,
    output logic                    err_tmo,
    output logic [2:0]              wb_addr,
    output logic [7:0]              wb_wr_data,
    input  logic [7:0]              wb_rd_data,
    output logic                    wb_we,
    output logic                    wb_stb,
    output logic                    wb_cyc,
    input  logic                    wb_ack
);

    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    // Core register map
    localparam logic [2:0] A_PRER_LO = 3'd0;
    localparam logic [2:0] A_PRER_HI = 3'd1;
    localparam logic [2:0] A_CTR     = 3'd2;
    localparam logic [2:0] A_TXR     = 3'd3;
    localparam logic [2:0] A_CR      = 3'd4;

    // Command register codes
    localparam logic [7:0] CR_STA_WR      = 8'h90;
    localparam logic [7:0] CR_WR          = 8'h10;
    localparam logic [7:0] CR_WR_STO      = 8'h50;
    localparam logic [7:0] CR_RD          = 8'h20;
    localparam logic [7:0] CR_RD_NACK_STO = 8'h68;
    localparam logic [7:0] CR_STO         = 8'h40;
    localparam logic [7:0] CTR_EN         = 8'h80;

    // Main sequencer states
    localparam logic [3:0] S_INIT_LO  = 4'd0;
    localparam logic [3:0] S_INIT_HI  = 4'd1;
    localparam logic [3:0] S_INIT_CTR = 4'd2;
    localparam logic [3:0] S_IDLE     = 4'd3;
    localparam logic [3:0] S_TXR      = 4'd4;
    localparam logic [3:0] S_CR       = 4'd5;
    localparam logic [3:0] S_POLL     = 4'd6;
    localparam logic [3:0] S_RXR      = 4'd7;
    localparam logic [3:0] S_ABORT    = 4'd8;
    localparam logic [3:0] S_DONE     = 4'd9;

    // What the current byte phase carries on the I2C bus
    localparam logic [2:0] PH_SA_W  = 3'd0;
    localparam logic [2:0] PH_MEM   = 3'd1;
    localparam logic [2:0] PH_SA_R  = 3'd2;
    localparam logic [2:0] PH_WDATA = 3'd3;
    localparam logic [2:0] PH_RDATA = 3'd4;

    logic [3:0]              state;
    logic [2:0]              kind;
    logic [1:0]              addr_idx;
    logic [LEN_W-1:0]        byte_idx;
    logic [TMO_W-1:0]        tmo_cnt;
    logic                    init_done;
    logic                    rw_q;
    logic [6:0]              sa_q;
    logic [LEN_W-1:0]        len_q;
    logic [8*ADDR_BYTES-1:0] mem_sr;   // address bytes, next one at the top
    logic [8*MAX_BYTES-1:0]  wr_sr;    // data bytes, next one at the bottom

    logic       last_addr;
    logic       last_byte;
    logic       tmo_hit;
    logic       start_bad;
    logic [7:0] tx_byte;
    logic [7:0] cr_code;
    logic       acc_we;
    logic [2:0] acc_addr;
    logic [7:0] acc_data;

    assign last_addr = (addr_idx == 2'(ADDR_BYTES - 1));
    assign last_byte = (byte_idx == len_q - LEN_W'(1));
    assign tmo_hit   = (tmo_cnt >= TMO_W'(TIMEOUT_CYC));
    assign start_bad = (len > LEN_W'(MAX_BYTES)) || (rw && (len == '0));

    // Byte to transmit and command code for the current byte phase
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        tx_byte = 8'h00;
        cr_code = CR_WR;
        case (kind)
            PH_SA_W: begin
                tx_byte = {sa_q, 1'b0};
                cr_code = CR_STA_WR;
            end
            PH_SA_R: begin
                tx_byte = {sa_q, 1'b1};
                cr_code = CR_STA_WR;
            end
            PH_MEM: begin
                tx_byte = mem_sr[8*ADDR_BYTES-1 -: 8];
                cr_code = (last_addr && !rw_q && (len_q == '0)) ? CR_WR_STO : CR_WR;
            end
            PH_WDATA: begin
                tx_byte = wr_sr[7:0];
                cr_code = last_byte ? CR_WR_STO : CR_WR;
            end
            PH_RDATA: begin
                cr_code = last_byte ? CR_RD_NACK_STO : CR_RD;
            end
            default: ;
        endcase
    end

    // Wishbone access that the current state issues when the bus is idle
    always_comb begin
        acc_we   = 1'b0;
        acc_addr = 3'd0;
        acc_data = 8'h00;
        case (state)
            S_INIT_LO:  begin acc_we = 1'b1; acc_addr = A_PRER_LO; acc_data = PRESCALE[7:0];  end
            S_INIT_HI:  begin acc_we = 1'b1; acc_addr = A_PRER_HI; acc_data = PRESCALE[15:8]; end
            S_INIT_CTR: begin acc_we = 1'b1; acc_addr = A_CTR;     acc_data = CTR_EN;         end
            S_TXR:      begin acc_we = 1'b1; acc_addr = A_TXR;     acc_data = tx_byte;        end
            S_CR:       begin acc_we = 1'b1; acc_addr = A_CR;      acc_data = cr_code;        end
            S_POLL:     begin acc_we = 1'b0; acc_addr = A_CR;                                 end
            S_RXR:      begin acc_we = 1'b0; acc_addr = A_TXR;                                end
            S_ABORT:    begin acc_we = 1'b1; acc_addr = A_CR;      acc_data = CR_STO;         end
            default: ;
        endcase
    end

    // Sequencer: init, transaction phases, bus handshake and status outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_INIT_LO;
            kind       <= PH_SA_W;
            addr_idx   <= '0;
            byte_idx   <= '0;
            tmo_cnt    <= '0;
            init_done  <= 1'b0;
            rw_q       <= 1'b0;
            sa_q       <= '0;
            len_q      <= '0;
            mem_sr     <= '0;
            wr_sr      <= '0;
            // NOTE: rd_data is a plain output register, not a RAM, so it is reset like any other flop.
            rd_data    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err_nack   <= 1'b0;
            err_tmo    <= 1'b0;
            wb_cyc     <= 1'b0;
            wb_stb     <= 1'b0;
            wb_we      <= 1'b0;
            wb_addr    <= '0;
            wb_wr_data <= '0;
        end else begin
            // NOTE: state uses non-blocking assignments so every flop updates from pre-edge values.
            done <= 1'b0;
            if (state == S_POLL && !tmo_hit)
                tmo_cnt <= tmo_cnt + TMO_W'(1);

            case (state)
                S_IDLE: begin
                    if (start && init_done) begin
                        rw_q     <= rw;
                        sa_q     <= slave_addr;
                        len_q    <= len;
                        mem_sr   <= mem_addr;
                        wr_sr    <= wr_data;
                        err_nack <= 1'b0;
                        err_tmo  <= 1'b0;
                        busy     <= 1'b1;
                        kind     <= PH_SA_W;
                        addr_idx <= '0;
                        byte_idx <= '0;
                        state    <= start_bad ? S_DONE : S_TXR;
                    end
                end

                S_DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end

                default: begin
                    if (!wb_cyc) begin
                        // Bus idle: either give up polling or launch this state's access.
                        if (state == S_POLL && tmo_hit) begin
                            err_tmo <= 1'b1;
                            state   <= S_ABORT;
                        end else begin
                            wb_cyc     <= 1'b1;
                            wb_stb     <= 1'b1;
                            wb_we      <= acc_we;
                            wb_addr    <= acc_addr;
                            wb_wr_data <= acc_data;
                        end
                    end else if (wb_ack) begin
                        // Access complete: release the bus for one idle cycle, then advance.
                        wb_cyc     <= 1'b0;
                        wb_stb     <= 1'b0;
                        wb_we      <= 1'b0;
                        wb_addr    <= '0;
                        wb_wr_data <= '0;
                        case (state)
                            S_INIT_LO:  state <= S_INIT_HI;
                            S_INIT_HI:  state <= S_INIT_CTR;
                            S_INIT_CTR: begin
                                init_done <= 1'b1;
                                state     <= S_IDLE;
                            end
                            S_TXR: state <= S_CR;
                            S_CR: begin
                                tmo_cnt <= '0;
                                state   <= S_POLL;
                            end
                            S_POLL: begin
                                if (!wb_rd_data[1]) begin
                                    if (kind != PH_RDATA && wb_rd_data[7]) begin
                                        err_nack <= 1'b1;
                                        state    <= S_ABORT;
                                    end else begin
                                        case (kind)
                                            PH_SA_W: begin
                                                kind     <= PH_MEM;
                                                addr_idx <= '0;
                                                state    <= S_TXR;
                                            end
                                            PH_MEM: begin
                                                mem_sr <= mem_sr << 8;
                                                if (!last_addr) begin
                                                    addr_idx <= addr_idx + 2'd1;
                                                    state    <= S_TXR;
                                                end else if (rw_q) begin
                                                    kind  <= PH_SA_R;
                                                    state <= S_TXR;
                                                end else if (len_q == '0) begin
                                                    state <= S_DONE;
                                                end else begin
                                                    kind     <= PH_WDATA;
                                                    byte_idx <= '0;
                                                    state    <= S_TXR;
                                                end
                                            end
                                            PH_SA_R: begin
                                                kind     <= PH_RDATA;
                                                byte_idx <= '0;
                                                state    <= S_CR;
                                            end
                                            PH_WDATA: begin
                                                if (last_byte) begin
                                                    state <= S_DONE;
                                                end else begin
                                                    byte_idx <= byte_idx + LEN_W'(1);
                                                    wr_sr    <= wr_sr >> 8;
                                                    state    <= S_TXR;
                                                end
                                            end
                                            PH_RDATA: state <= S_RXR;
                                            default:  state <= S_ABORT;
                                        endcase
                                    end
                                end
                            end
                            S_RXR: begin
                                for (int i = 0; i < MAX_BYTES; i++) begin
                                    if (byte_idx == LEN_W'(i))
                                        rd_data[8*i +: 8] <= wb_rd_data;
                                end
                                if (last_byte) begin
                                    state <= S_DONE;
                                end else begin
                                    byte_idx <= byte_idx + LEN_W'(1);
                                    state    <= S_CR;
                                end
                            end
                            S_ABORT: state <= S_DONE;
                            default: state <= S_IDLE;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_burst_master.sv
// Directed bench for i2c_burst_master: a Wishbone slave model with one wait
// state answers the master, and a scoreboard of expected register writes is
// filled as each transaction is started and drained as the writes occur.
`timescale 1ns/1ps
module tb_i2c_burst_master;

    localparam int MAXB = 4;
    localparam int AB   = 1;
    localparam int TMO  = 16;
    localparam int LW   = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic              rw = 1'b0;
    logic [6:0]        slave_addr = '0;
    logic [8*AB-1:0]   mem_addr = '0;
    logic [LW-1:0]     len = '0;
    logic [8*MAXB-1:0] wr_data = '0;
    logic [8*MAXB-1:0] rd_data;
    logic              busy, done, err_nack, err_tmo;
    logic [2:0]        wb_addr;
    logic [7:0]        wb_wr_data;
    logic [7:0]        wb_rd_data = '0;
    logic              wb_we, wb_stb, wb_cyc;
    logic              wb_ack = 1'b0;

    i2c_burst_master #(
        .PRESCALE   (16'h00C8),
        .MAX_BYTES  (MAXB),
        .ADDR_BYTES (AB),
        .TIMEOUT_CYC(TMO),
        .LEN_W      (LW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .rw        (rw),
        .slave_addr(slave_addr),
        .mem_addr  (mem_addr),
        .len       (len),
        .wr_data   (wr_data),
        .rd_data   (rd_data),
        .busy      (busy),
        .done      (done),
        .err_nack  (err_nack),
        .err_tmo   (err_tmo),
        .wb_addr   (wb_addr),
        .wb_wr_data(wb_wr_data),
        .wb_rd_data(wb_rd_data),
        .wb_we     (wb_we),
        .wb_stb    (wb_stb),
        .wb_cyc    (wb_cyc),
        .wb_ack    (wb_ack)
    );

    always #5 clk = ~clk;

    logic [10:0] exp_q[$];   // expected writes as {addr, data}
    logic [7:0]  rx_q[$];    // bytes the slave model returns from RXR
    int n_checks = 0;
    int n_fail   = 0;
    int cyc_no   = 0;
    int acc_cnt  = 0;
    int done_cnt = 0;
    int cr_cnt   = 0;
    int sr_reads = 0;
    int nack_at_cr = 0;
    bit stuck  = 1'b0;
    bit sb_off = 1'b0;
    int abort_cyc = 0;
    int cr90_cyc  = 0;
    int wait_cnt  = 0;
    bit tip, rxack;
    int d0, a0, done_at;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_w(input logic [2:0] a, input logic [7:0] d);
        exp_q.push_back({a, d});
    endtask

    always @(posedge clk) cyc_no <= cyc_no + 1;
    always @(negedge clk) if (done) done_cnt <= done_cnt + 1;

    // Wishbone slave model: one wait state, then ack for one cycle
    initial begin
        forever begin
            @(negedge clk);
            if (wb_ack) begin
                wb_ack   = 1'b0;
                wait_cnt = 0;
                check("idle_after_ack", {31'b0, wb_cyc}, 32'd0);
            end else if (wb_cyc) begin
                if (wait_cnt == 0) begin
                    wait_cnt = 1;
                end else begin
                    wb_ack = 1'b1;
                    acc_cnt++;
                    check("stb_with_cyc", {31'b0, wb_stb}, 32'd1);
                    if (wb_we) begin
                        if (wb_addr == 3'd4) begin
                            cr_cnt++;
                            sr_reads = 0;
                            if (wb_wr_data == 8'h40) abort_cyc = cyc_no;
                            if (wb_wr_data == 8'h90) cr90_cyc = cyc_no;
                        end
                        if (!sb_off) begin
                            if (exp_q.size() == 0)
                                check("unexpected_write", {21'b0, wb_addr, wb_wr_data}, 32'hFFFF_FFFF);
                            else
                                check("wb_write", {21'b0, wb_addr, wb_wr_data}, {21'b0, exp_q.pop_front()});
                        end
                    end else begin
                        case (wb_addr)
                            3'd4: begin
                                tip   = stuck || (sr_reads < 1);
                                rxack = (nack_at_cr != 0) && (cr_cnt == nack_at_cr);
                                sr_reads++;
                                wb_rd_data = {rxack, 5'b0, tip, 1'b0};
                            end
                            3'd3: begin
                                if (rx_q.size() > 0) begin
                                    wb_rd_data = rx_q.pop_front();
                                end else begin
                                    wb_rd_data = 8'h00;
                                    check("rxr_available", rx_q.size(), 32'd1);
                                end
                            end
                            default: check("read_addr", {29'b0, wb_addr}, 32'd4);
                        endcase
                    end
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    task automatic do_start(input logic r, input logic [6:0] sa, input logic [7:0] ma,
                            input logic [LW-1:0] l, input logic [31:0] wd);
        @(negedge clk);
        rw = r; slave_addr = sa; mem_addr = ma; len = l; wr_data = wd;
        cr_cnt = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (done) break;
            @(negedge clk);
        end
        check("done_seen", {31'b0, done}, 32'd1);
    endtask

    task automatic wait_sb_empty(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        check("writes_all_seen", exp_q.size(), 32'd0);
    endtask

    task automatic finish_txn(input logic en, input logic et, input int dbase);
        repeat (5) @(negedge clk);
        check("writes_all_seen", exp_q.size(), 32'd0);
        check("done_pulses", done_cnt, dbase + 1);
        check("err_nack", {31'b0, err_nack}, {31'b0, en});
        check("err_tmo", {31'b0, err_tmo}, {31'b0, et});
        check("busy_idle", {31'b0, busy}, 32'd0);
    endtask

    // Safety net so the run always ends
    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("reset_bus", {20'b0, wb_cyc, wb_stb, wb_we, wb_addr, wb_wr_data}, 32'd0);
        check("reset_status", {28'b0, busy, done, err_nack, err_tmo}, 32'd0);
        check("reset_rd_data", rd_data, 32'd0);

        // Init sequence; a start held during init must be ignored
        push_w(3'd0, 8'hC8); push_w(3'd1, 8'h00); push_w(3'd2, 8'h80);
        rw = 1'b0; slave_addr = 7'h10; mem_addr = 8'h06; len = 3'd1;
        rst = 1'b1;
        start = 1'b1;
        repeat (2) @(negedge clk);
        start = 1'b0;
        wait_sb_empty(200);
        a0 = acc_cnt;
        repeat (20) @(negedge clk);
        check("no_access_after_init", acc_cnt, a0);
        check("idle_after_init", {30'b0, busy, done}, 32'd0);
        check("no_done_during_init", done_cnt, 32'd0);

        // Two-byte write
        push_w(3'd3, 8'h20); push_w(3'd4, 8'h90);
        push_w(3'd3, 8'h06); push_w(3'd4, 8'h10);
        push_w(3'd3, 8'hEF); push_w(3'd4, 8'h10);
        push_w(3'd3, 8'hBE); push_w(3'd4, 8'h50);
        d0 = done_cnt;
        do_start(1'b0, 7'h10, 8'h06, 3'd2, 32'h0000_BEEF);
        check("busy_after_start", {31'b0, busy}, 32'd1);
        wait_done(400);
        finish_txn(1'b0, 1'b0, d0);

        // Three-byte read with repeated start
        rx_q.push_back(8'h11); rx_q.push_back(8'h22); rx_q.push_back(8'h33);
        push_w(3'd3, 8'h40); push_w(3'd4, 8'h90);
        push_w(3'd3, 8'h06); push_w(3'd4, 8'h10);
        push_w(3'd3, 8'h41); push_w(3'd4, 8'h90);
        push_w(3'd4, 8'h20); push_w(3'd4, 8'h20); push_w(3'd4, 8'h68);
        d0 = done_cnt;
        do_start(1'b1, 7'h20, 8'h06, 3'd3, 32'h0);
        wait_done(600);
        finish_txn(1'b0, 1'b0, d0);
        check("rd_data_read3", rd_data, 32'h0033_2211);
        check("rx_consumed", rx_q.size(), 32'd0);

        // NACK on the slave-address byte
        nack_at_cr = 1;
        push_w(3'd3, 8'h20); push_w(3'd4, 8'h90); push_w(3'd4, 8'h40);
        d0 = done_cnt;
        do_start(1'b0, 7'h10, 8'h06, 3'd2, 32'h0000_BEEF);
        wait_done(400);
        finish_txn(1'b1, 1'b0, d0);
        nack_at_cr = 0;
        check("rd_data_kept", rd_data, 32'h0033_2211);

        // TIP stuck: poll timeout
        stuck = 1'b1;
        push_w(3'd3, 8'h20); push_w(3'd4, 8'h90); push_w(3'd4, 8'h40);
        d0 = done_cnt;
        do_start(1'b0, 7'h10, 8'h06, 3'd1, 32'h0000_005A);
        wait_done(400);
        done_at = cyc_no;
        check("done_within_20_of_abort", {31'b0, (done_at - abort_cyc) <= 20}, 32'd1);
        check("poll_not_early", {31'b0, (abort_cyc - cr90_cyc) >= TMO}, 32'd1);
        check("poll_not_late", {31'b0, (abort_cyc - cr90_cyc) <= TMO + 10}, 32'd1);
        finish_txn(1'b0, 1'b1, d0);
        stuck = 1'b0;

        // Rejected requests: len above MAX_BYTES, and read of zero bytes
        d0 = done_cnt;
        a0 = acc_cnt;
        do_start(1'b0, 7'h10, 8'h06, 3'd5, 32'h0);
        check("reject_len_busy", {30'b0, busy, done}, 32'd2);
        @(negedge clk);
        check("reject_len_done", {28'b0, busy, done, err_nack, err_tmo}, 32'd4);
        do_start(1'b1, 7'h10, 8'h06, 3'd0, 32'h0);
        check("reject_rd0_busy", {30'b0, busy, done}, 32'd2);
        @(negedge clk);
        check("reject_rd0_done", {28'b0, busy, done, err_nack, err_tmo}, 32'd4);
        repeat (3) @(negedge clk);
        check("reject_no_bus", acc_cnt, a0);
        check("reject_done_pulses", done_cnt, d0 + 2);

        // Write of MAX_BYTES bytes
        push_w(3'd3, 8'h20); push_w(3'd4, 8'h90);
        push_w(3'd3, 8'h06); push_w(3'd4, 8'h10);
        push_w(3'd3, 8'h11); push_w(3'd4, 8'h10);
        push_w(3'd3, 8'h22); push_w(3'd4, 8'h10);
        push_w(3'd3, 8'h33); push_w(3'd4, 8'h10);
        push_w(3'd3, 8'h44); push_w(3'd4, 8'h50);
        d0 = done_cnt;
        do_start(1'b0, 7'h10, 8'h06, 3'd4, 32'h4433_2211);
        wait_done(800);
        finish_txn(1'b0, 1'b0, d0);

        // Write with no data bytes: STOP on the address byte
        push_w(3'd3, 8'h20); push_w(3'd4, 8'h90);
        push_w(3'd3, 8'h06); push_w(3'd4, 8'h50);
        d0 = done_cnt;
        do_start(1'b0, 7'h10, 8'h06, 3'd0, 32'h0);
        wait_done(400);
        finish_txn(1'b0, 1'b0, d0);

        // start while busy is ignored
        push_w(3'd3, 8'h20); push_w(3'd4, 8'h90);
        push_w(3'd3, 8'h06); push_w(3'd4, 8'h10);
        push_w(3'd3, 8'hAA); push_w(3'd4, 8'h50);
        d0 = done_cnt;
        do_start(1'b0, 7'h10, 8'h06, 3'd1, 32'h0000_00AA);
        repeat (6) @(negedge clk);
        rw = 1'b1; slave_addr = 7'h33; len = 3'd2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(400);
        finish_txn(1'b0, 1'b0, d0);
        a0 = acc_cnt;
        repeat (20) @(negedge clk);
        check("busy_start_ignored", acc_cnt, a0);

        // Reset in the middle of a read
        sb_off = 1'b1;
        rx_q.push_back(8'h77); rx_q.push_back(8'h88);
        a0 = acc_cnt;
        do_start(1'b1, 7'h20, 8'h06, 3'd2, 32'h0);
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #2;
            if (wb_cyc && (acc_cnt >= a0 + 4)) break;
        end
        rst = 1'b0;
        #1;
        check("rst_mid_cyc", {30'b0, wb_cyc, wb_stb}, 32'd0);
        check("rst_mid_busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        exp_q.delete();
        rx_q.delete();
        push_w(3'd0, 8'hC8); push_w(3'd1, 8'h00); push_w(3'd2, 8'h80);
        sb_off = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        wait_sb_empty(200);
        repeat (10) @(negedge clk);
        check("rerun_init_idle", {31'b0, busy}, 32'd0);
        check("rd_data_after_rst", rd_data, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_burst_master.md
Name: i2c_burst_master

Overview:
- Parametrised successor to the single-byte I2C sequencer: a Wishbone master that drives the I2C core register map.
- Performs multi-byte register-addressed writes or reads, up to MAX_BYTES per transaction, with 1..ADDR_BYTES memory-address bytes.
- Detects slave NACK and SR-poll timeouts, and always terminates a failed transfer with STOP.
- Sits between domain control logic and the I2C core's Wishbone slave port.

Parameters:
PRESCALE, 16'h00C8, value written to PRER_HI:PRER_LO during init.
MAX_BYTES, 4, maximum data bytes per transaction.
ADDR_BYTES, 1, memory-address bytes sent MSB first (1..4).
TIMEOUT_CYC, 1024, maximum clk cycles spent polling SR for one byte phase.
LEN_W, clog2(MAX_BYTES+1), width of len.

Ports:
clk  in  1  system clock; one clock; reset is asynchronous and active-low
rst  in  1  asynchronous active-low reset
start  in  1  transaction request, sampled only in IDLE
rw  in  1  1=read, 0=write
slave_addr  in  7  target I2C address
mem_addr  in  8*ADDR_BYTES  register address
len  in  LEN_W  data byte count
wr_data  in  8*MAX_BYTES  write bytes; byte 0 in [7:0], sent first
rd_data  out  8*MAX_BYTES  read bytes; byte 0 in [7:0]
busy  out  1  transaction in progress
done  out  1  one-cycle completion pulse
err_nack  out  1  slave NACK on the last transaction
err_tmo  out  1  poll timeout on the last transaction
wb_addr  out  3  Wishbone address
wb_wr_data  out  8  Wishbone write data
wb_rd_data  in  8  Wishbone read data
wb_we  out  1  write enable
wb_stb  out  1  strobe
wb_cyc  out  1  cycle
wb_ack  in  1  acknowledge

Behaviour:
- Reset (rst=0, async):
  - all outputs 0; rd_data 0.
  - FSM in INIT_LO; init_done=0.
- Register map: PRER_LO=0, PRER_HI=1, CTR=2, TXR/RXR=3, CR/SR=4.
- CR codes: STA|WR=0x90, WR=0x10, WR|STO=0x50, RD=0x20, RD|NACK|STO=0x68, STO=0x40.
- SR bits: bit1=TIP, bit7=RxACK.
- Wishbone access, all outputs registered:
  - cyc/stb/we/addr/data assert together and hold until wb_ack=1 is sampled.
  - They deassert on the following cycle; at least one idle cycle between accesses.
  - Reads capture wb_rd_data in the wb_ack cycle.
- Init, once after reset:
  - writes PRESCALE[7:0] to 0, PRESCALE[15:8] to 1, 0x80 to CTR.
  - then IDLE, init_done=1.
  - start during init is ignored.
- IDLE:
  - start=1 → latch all inputs, busy=1 the next cycle, clear err_*.
  - len>MAX_BYTES, or rw=1 with len=0 → no bus activity; done pulses 1 cycle later with err_nack=0, err_tmo=0, busy falls with done.
- Byte phase = TXR write (if transmitting) + CR write + SR poll.
  - Poll repeats SR reads until TIP=0.
  - In transmit phases, RxACK=1 → ABORT with err_nack=1.
- Write sequence:
  - {slave_addr,0} with 0x90.
  - Each mem_addr byte with 0x10; if len=0, the last address byte uses 0x50.
  - Data bytes 0..len-1 with 0x10; the last uses 0x50.
- Read sequence:
  - {slave_addr,0} with 0x90, then address bytes with 0x10.
  - {slave_addr,1} with 0x90 (repeated start).
  - Per byte: CR=0x20 (last byte 0x68), poll, read RXR into rd_data byte i.
  - RxACK is ignored during receive phases.
- Timeout:
  - Counter resets at each CR write and increments every cycle during the poll.
  - Reaching TIMEOUT_CYC → ABORT with err_tmo=1.
- ABORT:
  - CR=0x40, no poll, then DONE.
  - rd_data keeps bytes captured so far; the rest keep their previous values.
- DONE:
  - done=1 for one cycle, busy=0 in the same cycle; return to IDLE.
  - err_* hold until the next accepted start.
- Latency for a successful write with ADDR_BYTES=1, len=1:
  - 3 byte phases.
  - done no earlier than the cycle after the final SR read returns TIP=0.
- Reset mid-transaction: bus released immediately (cyc=stb=0); init is re-run.
- wb_ack outside an active access is ignored.

Test Plan:
- Reset release, slave BFM acks every access after 1 wait state → writes (0,0xC8), (1,0x00), (2,0x80) in order, then busy=0 and no further accesses.
- Write, sa=0x10, mem_addr=0x06, len=2, wr_data=0xBEEF, all ACK → TXR sequence 0x20, 0x06, 0xEF, 0xBE; CR sequence 0x90, 0x10, 0x10, 0x50; one done pulse; err_*=0.
- Read, sa=0x20, mem_addr=0x06, len=3, RXR returns 0x11, 0x22, 0x33 → TXR 0x40, 0x06, 0x41; CR sequence 0x90, 0x10, 0x90, 0x20, 0x20, 0x68; rd_data[23:0]=0x332211.
- Write where SR returns RxACK=1 after the slave-address byte → CR=0x40 issued, no data TXR writes, done with err_nack=1.
- TIP held at 1 for TIMEOUT_CYC cycles (TIMEOUT_CYC=16) → CR=0x40, err_tmo=1, done within 20 cycles of the CR write.
- Edge cases:
  - len=5 with MAX_BYTES=4 → done 1 cycle after start, no cyc.
  - start while busy → ignored.
  - rst pulsed mid-read → cyc=0 immediately, init re-run.
